// File: rtl/video_ctrl_pkg.sv
// Shared types and constants for the video generator control block.
package video_ctrl_pkg;

    localparam int LINE_W  = 12;
    localparam int FRAME_W = 16;

    localparam string POL_NEGATIVE = "NEGATIVE";
    localparam string POL_POSITIVE = "POSITIVE";

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // Line counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LINE_W-1:0] line_sat_inc(input logic [LINE_W-1:0] v);
        if (v == {LINE_W{1'b1}}) begin
            line_sat_inc = v;
        end else begin
            line_sat_inc = v + LINE_W'(1);
        end
    endfunction

endpackage

// File: rtl/video_gen_ctrl_if.sv
// Control, status and generator-timing signals between the controller and its host/generator.
interface video_gen_ctrl_if;
    import video_ctrl_pkg::*;

    logic               start_i;
    logic               stop_i;
    logic [FRAME_W-1:0] num_frames_i;
    logic               link_req_i;
    logic               repeat_req_i;
    logic               vsync_i;
    logic               data_valid_i;
    logic               video_gen_en_o;
    logic               link_o;
    logic               repeat_en_o;
    logic               busy_o;
    logic [FRAME_W-1:0] frame_cnt_o;
    logic               done_o;
    logic               line_err_o;
    logic               timeout_o;

    modport master (
        output start_i, stop_i, num_frames_i, link_req_i, repeat_req_i, vsync_i, data_valid_i,
        input  video_gen_en_o, link_o, repeat_en_o, busy_o, frame_cnt_o, done_o, line_err_o, timeout_o
    );

    modport slave (
        input  start_i, stop_i, num_frames_i, link_req_i, repeat_req_i, vsync_i, data_valid_i,
        output video_gen_en_o, link_o, repeat_en_o, busy_o, frame_cnt_o, done_o, line_err_o, timeout_o
    );

endinterface

// File: rtl/sync_edge_det.sv
// One register stage on a generator timing input plus a pulse on its transition into the active level.
module sync_edge_det
    import video_ctrl_pkg::*;
#(
    parameter string POLARITY = POL_POSITIVE
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic edge_pulse
);

    localparam logic ACTIVE_LVL = (POLARITY == POL_NEGATIVE) ? 1'b0 : 1'b1;

    logic sync_r;
    logic prev_r;

    // Sample the input and keep one cycle of history; reset parks both at the inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= ~ACTIVE_LVL;
            prev_r <= ~ACTIVE_LVL;
        end else begin
            sync_r <= din;
            prev_r <= sync_r;
        end
    end

    assign edge_pulse = (sync_r == ACTIVE_LVL) && (prev_r != ACTIVE_LVL);

endmodule

// File: rtl/video_gen_ctrl.sv
// Frame sequencer for a video pattern generator: arms on vsync, counts frames and
// lines, and applies link/repeat modes only on frame boundaries.
module video_gen_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int    EXP_LINES    = 768,
    parameter string VSYNC_POL    = POL_NEGATIVE,
    parameter int    ARM_TIMEOUT  = 2000000,
    parameter int    QUIET_CYCLES = 16
) (
    input logic             pixel_clock,
    input logic             rst,
    video_gen_ctrl_if.slave bus
);

    localparam int TMR_W = $clog2(ARM_TIMEOUT + 1);
    localparam int QW    = $clog2(QUIET_CYCLES + 1);
    localparam logic [LINE_W-1:0] EXP_LINE_CNT = LINE_W'(EXP_LINES);
    localparam logic [TMR_W-1:0]  TMR_LAST     = TMR_W'(ARM_TIMEOUT - 1);
    localparam logic [QW-1:0]     QUIET_LAST   = QW'(QUIET_CYCLES - 1);

    state_t             state_r, state_s;
    logic [FRAME_W-1:0] num_frames_r, num_frames_s;
    logic [FRAME_W-1:0] frame_cnt_r, frame_cnt_s, frame_inc_s;
    logic [LINE_W-1:0]  line_cnt_r, line_cnt_s, line_tot_s;
    logic [TMR_W-1:0]   tmr_r, tmr_s;
    logic [QW-1:0]      quiet_r, quiet_s;
    logic               stop_pend_r, stop_pend_s;
    logic               en_r, link_r, link_s, rep_r, rep_s, busy_r;
    logic               done_r, done_s, line_err_r, line_err_s, timeout_r, timeout_s;
    logic               frame_edge_s, line_evt_s;

    sync_edge_det #(.POLARITY(VSYNC_POL)) u_vsync_det (
        .clk(pixel_clock), .rst(rst), .din(bus.vsync_i), .edge_pulse(frame_edge_s)
    );

    sync_edge_det #(.POLARITY(POL_POSITIVE)) u_dv_det (
        .clk(pixel_clock), .rst(rst), .din(bus.data_valid_i), .edge_pulse(line_evt_s)
    );

    // Next-state and next-value logic for the sequencer and all registered outputs.
    always_comb begin
        state_s      = state_r;
        num_frames_s = num_frames_r;
        frame_cnt_s  = frame_cnt_r;
        line_cnt_s   = line_cnt_r;
        tmr_s        = tmr_r;
        quiet_s      = quiet_r;
        stop_pend_s  = stop_pend_r;
        link_s       = link_r;
        rep_s        = rep_r;
        done_s       = 1'b0;
        line_err_s   = line_err_r;
        timeout_s    = timeout_r;
        // A line arriving with the frame edge still belongs to the frame being closed.
        line_tot_s   = line_evt_s ? line_sat_inc(line_cnt_r) : line_cnt_r;
        frame_inc_s  = frame_cnt_r + FRAME_W'(1);

        case (state_r)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_s      = ST_ARM;
                    num_frames_s = bus.num_frames_i;
                    link_s       = bus.link_req_i;
                    rep_s        = bus.repeat_req_i;
                    frame_cnt_s  = {FRAME_W{1'b0}};
                    line_err_s   = 1'b0;
                    timeout_s    = 1'b0;
                    line_cnt_s   = {LINE_W{1'b0}};
                    tmr_s        = {TMR_W{1'b0}};
                    stop_pend_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (bus.stop_i) begin
                    stop_pend_s = 1'b1;
                    state_s     = ST_STOP;
                    quiet_s     = {QW{1'b0}};
                end else if (frame_edge_s) begin
                    state_s    = ST_RUN;
                    line_cnt_s = {LINE_W{1'b0}};
                end else if (tmr_r == TMR_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = ST_STOP;
                    quiet_s   = {QW{1'b0}};
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.stop_i) begin
                    stop_pend_s = 1'b1;
                end else begin
                    stop_pend_s = stop_pend_r;
                end
                if (frame_edge_s) begin
                    frame_cnt_s = frame_inc_s;
                    line_err_s  = line_err_r | (line_tot_s != EXP_LINE_CNT);
                    line_cnt_s  = {LINE_W{1'b0}};
                    link_s      = bus.link_req_i;
                    rep_s       = bus.repeat_req_i;
                    if (bus.stop_i || stop_pend_r ||
                        ((num_frames_r != {FRAME_W{1'b0}}) && (frame_inc_s == num_frames_r))) begin
                        state_s = ST_STOP;
                        quiet_s = {QW{1'b0}};
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    line_cnt_s = line_tot_s;
                end
            end
            ST_STOP: begin
                if (quiet_r == QUIET_LAST) begin
                    state_s     = ST_IDLE;
                    done_s      = 1'b1;
                    stop_pend_s = 1'b0;
                end else begin
                    quiet_s = quiet_r + QW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over everything, mid-frame included.
    always_ff @(posedge pixel_clock) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            num_frames_r <= {FRAME_W{1'b0}};
            frame_cnt_r  <= {FRAME_W{1'b0}};
            line_cnt_r   <= {LINE_W{1'b0}};
            tmr_r        <= {TMR_W{1'b0}};
            quiet_r      <= {QW{1'b0}};
            stop_pend_r  <= 1'b0;
            en_r         <= 1'b0;
            link_r       <= 1'b0;
            rep_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            line_err_r   <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            num_frames_r <= num_frames_s;
            frame_cnt_r  <= frame_cnt_s;
            line_cnt_r   <= line_cnt_s;
            tmr_r        <= tmr_s;
            quiet_r      <= quiet_s;
            stop_pend_r  <= stop_pend_s;
            en_r         <= (state_s == ST_ARM) || (state_s == ST_RUN);
            link_r       <= link_s;
            rep_r        <= rep_s;
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= done_s;
            line_err_r   <= line_err_s;
            timeout_r    <= timeout_s;
        end
    end

    assign bus.video_gen_en_o = en_r;
    assign bus.link_o         = link_r;
    assign bus.repeat_en_o    = rep_r;
    assign bus.busy_o         = busy_r;
    assign bus.frame_cnt_o    = frame_cnt_r;
    assign bus.done_o         = done_r;
    assign bus.line_err_o     = line_err_r;
    assign bus.timeout_o      = timeout_r;

endmodule

// File: tb/tb_video_gen_ctrl.sv
// Self-checking bench for video_gen_ctrl: table of whole-run scenarios with a
// done-driven scoreboard, plus hand sequences for timeout, mode timing and reset.
module tb_video_gen_ctrl;
    import video_ctrl_pkg::*;

    localparam int EXP   = 768;
    localparam int QUIET = 16;
    localparam int ATO   = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    video_gen_ctrl_if bus();

    video_gen_ctrl #(
        .EXP_LINES(EXP), .VSYNC_POL("NEGATIVE"), .ARM_TIMEOUT(ATO), .QUIET_CYCLES(QUIET)
    ) dut (
        .pixel_clock(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fc;
        logic        err;
        logic        to;
        logic        link;
        logic        rep;
    } exp_t;

    typedef struct {
        logic [15:0] nf;
        int          n_sent;
        int          lines_first;
        int          lines_rest;
        int          stop_frame;
        logic        coinc;
        logic        link_req;
        logic        rep_req;
        logic [15:0] exp_fc;
        logic        exp_err;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[5];

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            bus.data_valid_i = 1'b1;
            tick();
            bus.data_valid_i = 1'b0;
            tick();
        end
    endtask

    task automatic frame_edge(input logic with_line);
        bus.vsync_i      = 1'b0;
        bus.data_valid_i = with_line;
        tick();
        bus.vsync_i      = 1'b1;
        bus.data_valid_i = 1'b0;
        tick();
    endtask

    task automatic pulse_stop();
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] nf, input logic lk, input logic rp,
                            input logic with_stop, input string name);
        bus.num_frames_i = nf;
        bus.link_req_i   = lk;
        bus.repeat_req_i = rp;
        bus.start_i      = 1'b1;
        bus.stop_i       = with_stop;
        tick();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        check1({name, "_start_en"}, bus.video_gen_en_o, 1'b1);
        check1({name, "_start_busy"}, bus.busy_o, 1'b1);
        check16({name, "_start_fc"}, bus.frame_cnt_o, 16'd0);
        check1({name, "_start_err"}, bus.line_err_o, 1'b0);
        check1({name, "_start_to"}, bus.timeout_o, 1'b0);
        check1({name, "_start_link"}, bus.link_o, lk);
        check1({name, "_start_rep"}, bus.repeat_en_o, rp);
    endtask

    task automatic wait_done(input int bound, input int exp_lat, input string name);
        int k;
        k = 0;
        while ((bus.done_o !== 1'b1) && (k < bound)) begin
            tick();
            k++;
        end
        if (bus.done_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_done: done_o not seen within %0d cycles", name, bound);
        end else begin
            check32({name, "_done_latency"}, k, exp_lat);
            tick();
            check1({name, "_done_single"}, bus.done_o, 1'b0);
        end
    endtask

    // Scoreboard: each done pulse retires one expected end-of-run summary.
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_done: done_o=1 with no run outstanding");
            end else begin
                mon_e = exp_q.pop_front();
                check16("sb_frame_cnt", bus.frame_cnt_o, mon_e.fc);
                check1("sb_line_err", bus.line_err_o, mon_e.err);
                check1("sb_timeout", bus.timeout_o, mon_e.to);
                check1("sb_link", bus.link_o, mon_e.link);
                check1("sb_repeat", bus.repeat_en_o, mon_e.rep);
                check1("sb_busy", bus.busy_o, 1'b0);
                check1("sb_en", bus.video_gen_en_o, 1'b0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_lines;
        logic err_acc;

        vecs[0] = '{16'd3, 3, 768, 768, 0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0};
        vecs[1] = '{16'd0, 2, 768, 768, 2, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0};
        vecs[2] = '{16'd2, 2, 767, 768, 0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1};
        vecs[3] = '{16'd1, 1, 770, 770, 0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1};
        vecs[4] = '{16'd1, 1, 768, 768, 0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};

        bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.num_frames_i = 16'd0;
        bus.link_req_i = 1'b0; bus.repeat_req_i = 1'b0;
        bus.vsync_i = 1'b1; bus.data_valid_i = 1'b0;
        repeat (3) tick();
        check1("rst_en", bus.video_gen_en_o, 1'b0);
        check1("rst_busy", bus.busy_o, 1'b0);
        check16("rst_fc", bus.frame_cnt_o, 16'd0);
        check1("rst_done", bus.done_o, 1'b0);
        check1("rst_err", bus.line_err_o, 1'b0);
        check1("rst_to", bus.timeout_o, 1'b0);
        rst = 1'b0;
        tick();

        // vsync never arrives: abort after ARM_TIMEOUT cycles in ARM
        exp_q.push_back('{16'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        do_start(16'd1, 1'b0, 1'b0, 1'b0, "arm");
        repeat (ATO - 1) tick();
        check1("to_before_limit", bus.timeout_o, 1'b0);
        check1("en_before_limit", bus.video_gen_en_o, 1'b1);
        tick();
        check1("to_at_limit", bus.timeout_o, 1'b1);
        check1("en_at_limit", bus.video_gen_en_o, 1'b0);
        wait_done(40, QUIET, "timeout");
        repeat (3) tick();
        check1("to_sticky_idle", bus.timeout_o, 1'b1);

        // start+stop together, link change mid-frame, start ignored in RUN
        exp_q.push_back('{16'd2, 1'b0, 1'b0, 1'b1, 1'b0});
        do_start(16'd0, 1'b0, 1'b0, 1'b1, "link");
        tick();
        frame_edge(1'b0);
        lines(400);
        bus.link_req_i = 1'b1;
        bus.start_i    = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        lines(368);
        check1("link_mid_frame", bus.link_o, 1'b0);
        bus.vsync_i = 1'b0;
        tick();
        check1("link_at_edge_input", bus.link_o, 1'b0);
        bus.vsync_i = 1'b1;
        tick();
        check1("link_after_edge", bus.link_o, 1'b1);
        check16("link_fc1", bus.frame_cnt_o, 16'd1);
        check1("link_still_running", bus.video_gen_en_o, 1'b1);
        pulse_stop();
        lines(768);
        frame_edge(1'b0);
        check1("link_stop_en", bus.video_gen_en_o, 1'b0);
        wait_done(40, QUIET, "link");

        // reset mid-line while running, then stop in IDLE is ignored
        do_start(16'd0, 1'b1, 1'b1, 1'b0, "rstrun");
        tick();
        frame_edge(1'b0);
        lines(768);
        frame_edge(1'b0);
        check16("rstrun_fc_before", bus.frame_cnt_o, 16'd1);
        lines(100);
        bus.data_valid_i = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check1("rstrun_en", bus.video_gen_en_o, 1'b0);
        check1("rstrun_link", bus.link_o, 1'b0);
        check1("rstrun_rep", bus.repeat_en_o, 1'b0);
        check1("rstrun_busy", bus.busy_o, 1'b0);
        check16("rstrun_fc", bus.frame_cnt_o, 16'd0);
        check1("rstrun_done", bus.done_o, 1'b0);
        check1("rstrun_err", bus.line_err_o, 1'b0);
        check1("rstrun_to", bus.timeout_o, 1'b0);
        rst = 1'b0;
        bus.data_valid_i = 1'b0;
        tick();
        pulse_stop();
        tick();
        check1("idle_stop_ignored", bus.busy_o, 1'b0);

        // whole-run scenario table
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back('{vecs[v].exp_fc, vecs[v].exp_err, 1'b0, vecs[v].link_req, vecs[v].rep_req});
            do_start(vecs[v].nf, vecs[v].link_req, vecs[v].rep_req, 1'b0, "vec");
            tick();
            frame_edge(1'b0);
            err_acc = 1'b0;
            for (int f = 1; f <= vecs[v].n_sent; f++) begin
                n_lines = (f == 1) ? vecs[v].lines_first : vecs[v].lines_rest;
                if (f == vecs[v].stop_frame) begin
                    lines(n_lines / 2);
                    pulse_stop();
                    lines(n_lines - n_lines / 2);
                end else if (vecs[v].coinc && (f == vecs[v].n_sent)) begin
                    lines(n_lines - 1);
                end else begin
                    lines(n_lines);
                end
                err_acc = err_acc | (n_lines != EXP);
                check1("vec_en_before_edge", bus.video_gen_en_o, 1'b1);
                frame_edge(vecs[v].coinc && (f == vecs[v].n_sent));
                check16("vec_frame_cnt", bus.frame_cnt_o, 16'(f));
                check1("vec_line_err", bus.line_err_o, err_acc);
                check1("vec_en_after_edge", bus.video_gen_en_o, f < vecs[v].n_sent);
            end
            wait_done(40, QUIET, "vec");
            repeat (3) tick();
            check16("vec_fc_hold", bus.frame_cnt_o, vecs[v].exp_fc);
            check1("vec_err_hold", bus.line_err_o, vecs[v].exp_err);
        end

        check32("sb_outstanding", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_gen_ctrl.md
VIDEO_GEN_CTRL -- requirements
Module: video_gen_ctrl

Interface
REQ-001 SHALL have parameter EXP_LINES, default 768: active lines (data_valid pulses) expected per frame.
REQ-002 SHALL have parameter VSYNC_POL, default "NEGATIVE": active level of vsync_i ("NEGATIVE" = low, "POSITIVE" = high).
REQ-003 SHALL have parameter ARM_TIMEOUT, default 2000000: max pixel_clock cycles in ARM before abort.
REQ-004 SHALL have parameter QUIET_CYCLES, default 16: cycles video_gen_en_o is held low in STOP.
REQ-005 pixel_clock  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start_i  in  1  single-cycle start request.
REQ-008 stop_i  in  1  single-cycle stop request.
REQ-009 num_frames_i  in  16  frames to run; 0 = run until stopped.
REQ-010 link_req_i / repeat_req_i  in  1 each  requested link mode (0 single, 1 dual) / bmp repeat mode.
REQ-011 vsync_i, data_valid_i  in  1 each  generator timing outputs.
REQ-012 video_gen_en_o  out  1  generator enable.
REQ-013 link_o / repeat_en_o  out  1 each  registered modes applied to generator.
REQ-014 busy_o  out  1  high when state is not IDLE.
REQ-015 frame_cnt_o  out  16  completed frames this run.
REQ-016 done_o  out  1  one-cycle pulse on STOP->IDLE.
REQ-017 line_err_o / timeout_o  out  1 each  sticky error flags.

Function
REQ-018 SHALL implement states IDLE, ARM, RUN, STOP.
REQ-019 vsync_i and data_valid_i SHALL each be registered once; a frame edge is the registered vsync transition into its active level; a line event is a registered data_valid 0->1 transition; both are visible to the FSM one cycle after the input change.
REQ-020 IDLE: video_gen_en_o=0; on start_i -> ARM, latching num_frames_i, link_o<=link_req_i, repeat_en_o<=repeat_req_i, frame_cnt_o<=0, line_err_o<=0, timeout_o<=0, line counter<=0.
REQ-021 start_i outside IDLE SHALL be ignored; stop_i in IDLE SHALL be ignored; start_i and stop_i together in IDLE -> start taken, stop discarded.
REQ-022 ARM: video_gen_en_o=1; on first frame edge -> RUN, clear line counter; after ARM_TIMEOUT cycles without an edge -> set timeout_o, -> STOP.
REQ-023 RUN: video_gen_en_o=1; each line event increments a 12-bit line counter, saturating at 4095.
REQ-024 On each frame edge in RUN: frame_cnt_o increments (wraps 65535->0); line_err_o set if line counter != EXP_LINES; line counter cleared; link_o and repeat_en_o resampled from the request inputs. Mode changes SHALL never occur mid-frame.
REQ-025 stop_i in ARM or RUN SHALL set stop_pending; in ARM it takes effect immediately (-> STOP); in RUN it takes effect at the next frame edge.
REQ-026 At a RUN frame edge, -> STOP if stop_pending, or if num_frames != 0 and the incremented frame_cnt_o == num_frames; otherwise stay in RUN.
REQ-027 STOP: video_gen_en_o=0 for exactly QUIET_CYCLES cycles, then -> IDLE with done_o high for that one cycle; stop_pending cleared.
REQ-028 A frame edge and a line event in the same cycle: the line is counted into the completed frame before the comparison.
REQ-029 frame_cnt_o, line_err_o and timeout_o SHALL hold their values in IDLE until the next accepted start_i.

Reset
REQ-030 rst SHALL override all activity, including mid-frame: state=IDLE, video_gen_en_o=0, link_o=0, repeat_en_o=0, busy_o=0, frame_cnt_o=0, done_o=0, line_err_o=0, timeout_o=0, all counters and edge registers=0 (edge registers loaded with the inactive vsync level).

Structure
REQ-031 Shared package video_ctrl_pkg SHALL hold the state enum typedef, the 12-bit line-count and 16-bit frame-count width constants, and the polarity string constants.
REQ-032 One sub-module, sync_edge_det (register stage plus polarity-aware edge pulse), SHALL be instantiated for vsync_i and for data_valid_i.

Verification
REQ-033 num_frames=3, EXP_LINES=768, correct generator: en high from cycle after start through 3rd frame edge; frame_cnt_o=3; done_o pulses once QUIET_CYCLES after; line_err_o=0.
REQ-034 num_frames=0, stop_i mid-frame 2: en stays high until end of frame 2; frame_cnt_o=2; done_o pulses.
REQ-035 Toggle link_req_i 0->1 mid-frame 1: link_o changes one cycle after the frame-1 edge, never before.
REQ-036 Frame with 767 data_valid pulses: line_err_o=1 after that frame edge and stays set until the next start.
REQ-037 vsync_i held inactive, ARM_TIMEOUT=100: timeout_o=1 at cycle 100 of ARM; STOP, then done_o.
REQ-038 rst asserted in RUN mid-line: next cycle all outputs at reset values; a subsequent start_i runs normally.
